// File: rtl/bmem_line_arbiter.sv
// Round-robin arbiter between icache and dcache line requests, adapting each
// grant to a 4-beat banked-memory burst and reassembling read lines.
module bmem_line_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_BURST,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]        cnt;
  logic              last;      // 0 = icache, 1 = dcache
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] i_line_q;
  logic [LINE_W-1:0] d_line_q;

  logic              i_req;
  logic              d_req;
  logic              any_req;
  logic              pick_d;
  logic [ADDR_W-1:0] sel_addr;
  logic              beat_hit;

  assign i_req    = i_read;
  assign d_req    = d_read | d_write;
  assign any_req  = i_req | d_req;
  // On a tie the client that was not granted last time wins.
  assign pick_d   = d_req & (~i_req | ~last);
  assign sel_addr = pick_d ? d_addr : i_addr;
  assign beat_hit = bmem_rvalid & (bmem_raddr == addr_q);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (any_req) state_nx = (pick_d && d_write) ? WR_BURST : RD_ISSUE;
      RD_ISSUE: if (bmem_ready) state_nx = RD_WAIT;
      RD_WAIT:  if (beat_hit && cnt == 2'd3) state_nx = DONE;
      WR_BURST: if (bmem_ready && cnt == 2'd3) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b0;
      addr_q   <= '0;
      line_q   <= '0;
      i_line_q <= '0;
      d_line_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (any_req) begin
            last   <= pick_d;
            addr_q <= sel_addr & ~ADDR_W'(5'h1f);
            cnt    <= '0;
            if (pick_d && d_write) line_q <= d_wdata;
          end
        end
        RD_WAIT: begin
          if (beat_hit) begin
            line_q[BEAT_W*32'(cnt) +: BEAT_W] <= bmem_rdata;
            cnt <= cnt + 2'd1;
            // Final beat goes straight into the client's response line.
            if (cnt == 2'd3) begin
              if (last) d_line_q <= {bmem_rdata, line_q[LINE_W-BEAT_W-1:0]};
              else      i_line_q <= {bmem_rdata, line_q[LINE_W-BEAT_W-1:0]};
            end
          end
        end
        WR_BURST: begin
          if (bmem_ready) cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bmem_addr  = addr_q;
  assign bmem_read  = (state == RD_ISSUE);
  assign bmem_write = (state == WR_BURST);
  assign bmem_wdata = (state == WR_BURST) ? line_q[BEAT_W*32'(cnt) +: BEAT_W] : '0;
  assign i_resp     = (state == DONE) & ~last;
  assign d_resp     = (state == DONE) & last;
  assign i_rdata    = i_line_q;
  assign d_rdata    = d_line_q;

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Directed transaction table plus hand-written reset sequence for
// bmem_line_arbiter; the bench plays the banked memory.
module tb_bmem_line_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr, d_addr;
  logic         i_read, d_read, d_write;
  logic [255:0] d_wdata;
  logic [255:0] i_rdata, d_rdata;
  logic         i_resp, d_resp;
  logic [31:0]  bmem_addr, bmem_raddr;
  logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0]  bmem_wdata, bmem_rdata;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  bmem_line_arbiter #(.LINE_W(256), .BEAT_W(64), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  typedef struct {
    bit           tie;      // both i_read and d_read raised
    bit           cl;       // expected winner: 0 icache, 1 dcache
    bit           wr;
    bit           both;     // d_read and d_write together
    bit           inject;   // stray rvalid in IDLE + mismatched beat in RD_WAIT
    logic [31:0]  addr;
    logic [31:0]  exp_addr;
    logic [255:0] wline;
    logic [7:0]   rdy;      // bmem_ready per command cycle, LSB first
    int unsigned  lat;      // cycles from request (IDLE) to resp
  } txn_t;

  txn_t tv[10];

  function automatic txn_t mk(bit tie, bit cl, bit wr, bit both, bit inject,
                              logic [31:0] addr, logic [31:0] exp_addr,
                              logic [255:0] wline, logic [7:0] rdy, int unsigned lat);
    txn_t t;
    t.tie = tie; t.cl = cl; t.wr = wr; t.both = both; t.inject = inject;
    t.addr = addr; t.exp_addr = exp_addr; t.wline = wline; t.rdy = rdy; t.lat = lat;
    return t;
  endfunction

  function automatic logic [63:0] bv(input logic [31:0] a, input int unsigned j);
    return {a, 32'hA0A0_0000 + j};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bmem_addr"},  bmem_addr, '0);
    chk({tag, "_bmem_read"},  bmem_read, '0);
    chk({tag, "_bmem_write"}, bmem_write, '0);
    chk({tag, "_bmem_wdata"}, bmem_wdata, '0);
    chk({tag, "_i_resp"},     i_resp, '0);
    chk({tag, "_d_resp"},     d_resp, '0);
    chk({tag, "_i_rdata"},    i_rdata, '0);
    chk({tag, "_d_rdata"},    d_rdata, '0);
  endtask

  // Called in an IDLE cycle (posedge + 1); returns in the IDLE cycle after DONE.
  task automatic run_txn(input txn_t t, input int idx);
    int unsigned  cyc, k, beat;
    bit           accepted, done, injected, own, other;
    logic [255:0] exp_line;
    string        nm;
    nm = $sformatf("t%0d", idx);
    exp_line = {bv(t.exp_addr, 3), bv(t.exp_addr, 2), bv(t.exp_addr, 1), bv(t.exp_addr, 0)};
    i_read = 0; d_read = 0; d_write = 0;
    if (t.tie) begin
      i_read = 1; d_read = 1;
      i_addr = t.cl ? (t.addr ^ 32'h100) : t.addr;
      d_addr = t.cl ? t.addr : (t.addr ^ 32'h100);
    end else if (!t.cl) begin
      i_read = 1; i_addr = t.addr;
    end else begin
      d_addr = t.addr; d_wdata = t.wline;
      d_write = t.wr; d_read = !t.wr || t.both;
    end
    if (t.inject) begin
      bmem_rvalid = 1; bmem_raddr = t.exp_addr; bmem_rdata = '1;
    end
    cyc = 0; k = 0; beat = 0; accepted = 0; done = 0; injected = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      bmem_rvalid = 0; bmem_ready = 1;
      own   = t.cl ? d_resp : i_resp;
      other = t.cl ? i_resp : d_resp;
      chk({nm, "_other_resp"}, other, 0);
      if (own) begin
        chk({nm, "_latency"}, cyc, t.lat);
        if (!t.wr) chk({nm, "_rdata"}, t.cl ? d_rdata : i_rdata, exp_line);
        done = 1;
        i_read = 0; d_read = 0; d_write = 0;
      end else if (bmem_read || bmem_write) begin
        chk({nm, "_addr"}, bmem_addr, t.exp_addr);
        chk({nm, "_kind"}, bmem_write, t.wr);
        bmem_ready = (k < 8) ? t.rdy[k] : 1'b1;
        k++;
        if (bmem_write && bmem_ready && beat < 4) begin
          chk($sformatf("%s_wbeat%0d", nm, beat), bmem_wdata, t.wline[64*beat +: 64]);
          beat++;
        end
        if (bmem_read && bmem_ready) accepted = 1;
      end else if (accepted && beat < 4) begin
        bmem_rvalid = 1;
        if (t.inject && beat == 1 && !injected) begin
          bmem_raddr = 32'hDEAD_0000; bmem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
          injected = 1;
        end else begin
          bmem_raddr = t.exp_addr; bmem_rdata = bv(t.exp_addr, beat);
          beat++;
        end
      end
    end
    if (!done) begin
      chk({nm, "_timeout"}, 1, 0);
      i_read = 0; d_read = 0; d_write = 0;
    end
    tick();
    chk({nm, "_resp_one_cycle"}, t.cl ? d_resp : i_resp, 0);
  endtask

  initial begin
    bit seen;
    rst = 0; i_addr = '0; d_addr = '0; i_read = 0; d_read = 0; d_write = 0;
    d_wdata = '0; bmem_ready = 1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 0;

    tv[0] = mk(1, 1, 0, 0, 0, 32'h0000_3000, 32'h0000_3000, '0, 8'hFF, 6);
    tv[1] = mk(1, 0, 0, 0, 0, 32'h0000_3404, 32'h0000_3400, '0, 8'hFF, 6);
    tv[2] = mk(1, 1, 0, 0, 0, 32'h0000_3808, 32'h0000_3800, '0, 8'hFF, 6);
    tv[3] = mk(1, 0, 0, 0, 0, 32'h0000_3C10, 32'h0000_3C00, '0, 8'hFF, 6);
    tv[4] = mk(0, 0, 0, 0, 0, 32'h0000_1234, 32'h0000_1220, '0, 8'hFF, 6);
    tv[5] = mk(0, 1, 1, 0, 0, 32'h8000_0040, 32'h8000_0040,
               {64'h3333_3333_CCCC_CCCC, 64'h2222_2222_DDDD_DDDD,
                64'h1111_1111_EEEE_EEEE, 64'h0000_0000_FFFF_FFFF}, 8'h2D, 7);
    tv[6] = mk(0, 1, 0, 0, 0, 32'h0000_10FF, 32'h0000_10E0, '0, 8'hFC, 8);
    tv[7] = mk(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEE0, '0, 8'hFF, 7);
    tv[8] = mk(0, 1, 1, 0, 0, 32'h0000_001F, 32'h0000_0000,
               {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0}, 8'hFF, 5);
    tv[9] = mk(0, 1, 1, 1, 0, 32'h4000_0024, 32'h4000_0020,
               {64'hA1A1_A1A1_A1A1_A1A1, 64'hB2B2_B2B2_B2B2_B2B2,
                64'hC3C3_C3C3_C3C3_C3C3, 64'hD4D4_D4D4_D4D4_D4D4}, 8'hFF, 5);

    repeat (3) tick();
    chk_zero("reset");
    rst = 1;
    tick();

    for (int i = 0; i < 10; i++) run_txn(tv[i], i);

    // Reset one cycle after the second read beat abandons the transaction.
    i_addr = 32'h2000_0008; i_read = 1;
    tick();
    bmem_ready = 1;
    tick();
    bmem_rvalid = 1; bmem_raddr = 32'h2000_0000; bmem_rdata = bv(32'h2000_0000, 0);
    tick();
    bmem_rdata = bv(32'h2000_0000, 1);
    tick();
    bmem_rvalid = 0; rst = 0; i_read = 0;
    tick();
    rst = 1;
    chk_zero("midrst");
    seen = 0;
    repeat (8) begin
      tick();
      if (i_resp || d_resp) seen = 1;
    end
    chk("midrst_no_resp", seen, 0);
    run_txn(mk(0, 0, 0, 0, 0, 32'h2000_0008, 32'h2000_0000, '0, 8'hFF, 6), 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
